multicycle_ctrl: RTL and testbench

//  Moore/Mealy FSM that sequences a multicycle MIPS datapath with one shared memory, ALU and register file.
//  It replaces the single-cycle control_unit and the free-running PC update.
//  Per state it drives the PC, IR, memory, register-file and ALU operand/operation selects.
//  It waits on a memory ready handshake, times out hung accesses, flags illegal opcodes and counts retired instructions.

---
 rtl/multicycle_ctrl_if.sv | 39 +++
 rtl/multicycle_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle sequencer and the MIPS datapath.
// master = sequencer side, slave = datapath side.
interface multicycle_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       opcode;
    logic             mem_ready;
    logic             pc_write;
    logic             pc_write_cond;
    logic [1:0]       pc_source;
    logic             iord;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic [1:0]       reg_dst;
    logic [1:0]       mem_to_reg;
    logic             reg_write;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic [3:0]       state;
    logic             illegal_op;
    logic             mem_err;
    logic [CNT_W-1:0] instr_retired;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, pc_source, iord, mem_read, mem_write,
               ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
               alu_op, state, illegal_op, mem_err, instr_retired
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, pc_source, iord, mem_read, mem_write,
               ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
               alu_op, state, illegal_op, mem_err, instr_retired
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute over a shared
// memory, waits on mem_ready with a hang timeout, and counts retired instructions.
module multicycle_ctrl #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    multicycle_ctrl_if.master bus
);
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9,
        S_ADDI_EX = 4'd10,
        S_ADDI_WB = 4'd11,
        S_JAL     = 4'd12
    } state_t;

    localparam logic [5:0]       OP_RTYPE = 6'b000000;
    localparam logic [5:0]       OP_LW    = 6'b100011;
    localparam logic [5:0]       OP_SW    = 6'b101011;
    localparam logic [5:0]       OP_BEQ   = 6'b000100;
    localparam logic [5:0]       OP_J     = 6'b000010;
    localparam logic [5:0]       OP_JAL   = 6'b000011;
    localparam logic [5:0]       OP_ADDI  = 6'b001000;
    localparam logic [7:0]       TO_LIM   = 8'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           r_state;
    logic [7:0]       r_wait_cnt;
    logic [CNT_W-1:0] r_retired;

    state_t w_next;
    logic   w_waiting;
    logic   w_timeout;
    logic   w_illegal;
    logic   w_retire;

    assign w_waiting = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
    // A mem_ready in the timeout cycle takes priority: the access completes normally.
    assign w_timeout = w_waiting && !bus.mem_ready && (r_wait_cnt == TO_LIM);

    always_comb begin
        w_next    = r_state;
        w_illegal = 1'b0;
        w_retire  = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (bus.mem_ready)  w_next = S_DECODE;
                else if (w_timeout) w_next = S_FETCH;
            end
            S_DECODE: begin
                case (bus.opcode)
                    OP_RTYPE:      w_next = S_EXEC;
                    OP_LW, OP_SW:  w_next = S_MEMADR;
                    OP_BEQ:        w_next = S_BRANCH;
                    OP_J:          w_next = S_JUMP;
                    OP_JAL:        w_next = S_JAL;
                    OP_ADDI:       w_next = S_ADDI_EX;
                    default: begin
                        w_next    = S_FETCH;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR:  w_next = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD: begin
                if (bus.mem_ready)  w_next = S_MEMWB;
                else if (w_timeout) w_next = S_FETCH;
            end
            S_MEMWB: begin
                w_next   = S_FETCH;
                w_retire = 1'b1;
            end
            S_MEMWR: begin
                if (bus.mem_ready) begin
                    w_next   = S_FETCH;
                    w_retire = 1'b1;
                end else if (w_timeout) begin
                    w_next = S_FETCH;
                end
            end
            S_EXEC:    w_next = S_ALUWB;
            S_ADDI_EX: w_next = S_ADDI_WB;
            S_ALUWB, S_BRANCH, S_JUMP, S_JAL, S_ADDI_WB: begin
                w_next   = S_FETCH;
                w_retire = 1'b1;
            end
            default:   w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_FETCH;
            r_wait_cnt <= 8'd0;
            r_retired  <= '0;
        end else begin
            r_state <= w_next;
            // Counter only runs while stalled in a memory state; any exit or ready clears it.
            if (w_waiting && !bus.mem_ready && !w_timeout && (w_next == r_state))
                r_wait_cnt <= r_wait_cnt + 8'd1;
            else
                r_wait_cnt <= 8'd0;
            if (w_retire)
                r_retired <= r_retired + CNT_ONE;
        end
    end

    // Outputs decode from the async-reset state register so strobes drop with rst_n.
    always_comb begin
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.pc_source     = 2'b00;
        bus.iord          = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.ir_write      = 1'b0;
        bus.reg_dst       = 2'b00;
        bus.mem_to_reg    = 2'b00;
        bus.reg_write     = 1'b0;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = 2'b00;
        bus.alu_op        = 2'b00;
        case (r_state)
            S_FETCH: begin
                bus.mem_read  = 1'b1;
                bus.alu_src_b = 2'b01;
                bus.ir_write  = bus.mem_ready;
                bus.pc_write  = bus.mem_ready;
            end
            S_DECODE:  bus.alu_src_b = 2'b11;
            S_MEMADR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                bus.mem_read = 1'b1;
                bus.iord     = 1'b1;
            end
            S_MEMWB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 2'b01;
            end
            S_MEMWR: begin
                bus.mem_write = 1'b1;
                bus.iord      = 1'b1;
            end
            S_EXEC: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = 2'b10;
            end
            S_ALUWB: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = 2'b01;
            end
            S_BRANCH: begin
                bus.alu_src_a     = 1'b1;
                bus.alu_op        = 2'b01;
                bus.pc_write_cond = 1'b1;
                bus.pc_source     = 2'b01;
            end
            S_JUMP: begin
                bus.pc_write  = 1'b1;
                bus.pc_source = 2'b10;
            end
            S_JAL: begin
                bus.pc_write   = 1'b1;
                bus.pc_source  = 2'b10;
                bus.reg_write  = 1'b1;
                bus.reg_dst    = 2'b10;
                bus.mem_to_reg = 2'b10;
            end
            S_ADDI_EX: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
            end
            S_ADDI_WB: bus.reg_write = 1'b1;
            default: ;
        endcase
    end

    assign bus.state         = r_state;
    assign bus.illegal_op    = w_illegal;
    assign bus.mem_err       = w_timeout;
    assign bus.instr_retired = r_retired;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed vector bench for multicycle_ctrl: one cycle per table row, plus
// hand sequences for asynchronous reset during a memory access.
module tb_multicycle_ctrl;
    localparam int CNT_W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    multicycle_ctrl_if #(.CNT_W(CNT_W)) bus ();
    multicycle_ctrl #(.CNT_W(CNT_W), .TIMEOUT(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    logic [19:0] ctl_act;
    assign ctl_act = {bus.pc_write, bus.pc_write_cond, bus.pc_source, bus.iord,
                      bus.mem_read, bus.mem_write, bus.ir_write, bus.reg_dst,
                      bus.mem_to_reg, bus.reg_write, bus.alu_src_a, bus.alu_src_b,
                      bus.alu_op, bus.illegal_op, bus.mem_err};

    typedef struct {
        logic [5:0]  op;
        logic        mr;
        logic [3:0]  st;
        logic [19:0] ctl;
        int          ret;
    } vec_t;
    vec_t vecs[$];

    function automatic logic [19:0] ctl(input logic pw, pwc, input logic [1:0] ps,
                                        input logic iord, mr, mw, irw,
                                        input logic [1:0] rd, m2r, input logic rw, sa,
                                        input logic [1:0] sb, op, input logic ill, me);
        return {pw, pwc, ps, iord, mr, mw, irw, rd, m2r, rw, sa, sb, op, ill, me};
    endfunction

    logic [19:0] C_FW, C_FG, C_FT, C_DEC, C_DILL, C_MA, C_MRD, C_MRDT, C_MWB, C_MWR;
    logic [19:0] C_EX, C_AWB, C_BR, C_J, C_JAL, C_AEX, C_AWB2;

    task automatic add(input logic [5:0] op, input logic mr, input logic [3:0] st,
                       input logic [19:0] c, input int ret);
        vec_t v;
        v.op = op; v.mr = mr; v.st = st; v.ctl = c; v.ret = ret;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        //          pw pwc ps   io mr mw ir rd    m2r   rw sa sb    op    il me
        C_FW   = ctl(0, 0, 2'b00, 0, 1, 0, 0, 2'b00, 2'b00, 0, 0, 2'b01, 2'b00, 0, 0);
        C_FG   = ctl(1, 0, 2'b00, 0, 1, 0, 1, 2'b00, 2'b00, 0, 0, 2'b01, 2'b00, 0, 0);
        C_FT   = ctl(0, 0, 2'b00, 0, 1, 0, 0, 2'b00, 2'b00, 0, 0, 2'b01, 2'b00, 0, 1);
        C_DEC  = ctl(0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2'b11, 2'b00, 0, 0);
        C_DILL = ctl(0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2'b11, 2'b00, 1, 0);
        C_MA   = ctl(0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 2'b10, 2'b00, 0, 0);
        C_MRD  = ctl(0, 0, 2'b00, 1, 1, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0);
        C_MRDT = ctl(0, 0, 2'b00, 1, 1, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 0, 1);
        C_MWB  = ctl(0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b01, 1, 0, 2'b00, 2'b00, 0, 0);
        C_MWR  = ctl(0, 0, 2'b00, 1, 0, 1, 0, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0);
        C_EX   = ctl(0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 2'b00, 2'b10, 0, 0);
        C_AWB  = ctl(0, 0, 2'b00, 0, 0, 0, 0, 2'b01, 2'b00, 1, 0, 2'b00, 2'b00, 0, 0);
        C_BR   = ctl(0, 1, 2'b01, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 2'b00, 2'b01, 0, 0);
        C_J    = ctl(1, 0, 2'b10, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0);
        C_JAL  = ctl(1, 0, 2'b10, 0, 0, 0, 0, 2'b10, 2'b10, 1, 0, 2'b00, 2'b00, 0, 0);
        C_AEX  = ctl(0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 2'b10, 2'b00, 0, 0);
        C_AWB2 = ctl(0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0, 2'b00, 2'b00, 0, 0);

        // R-type, all ready
        add(6'b000000, 1, 0, C_FG, 0);  add(6'b000000, 1, 1, C_DEC, 0);
        add(6'b000000, 1, 6, C_EX, 0);  add(6'b000000, 1, 7, C_AWB, 0);
        // lw with two wait cycles in MEMRD
        add(6'b100011, 1, 0, C_FG, 1);  add(6'b100011, 1, 1, C_DEC, 1);
        add(6'b100011, 1, 2, C_MA, 1);  add(6'b100011, 0, 3, C_MRD, 1);
        add(6'b100011, 0, 3, C_MRD, 1); add(6'b100011, 1, 3, C_MRD, 1);
        add(6'b100011, 1, 4, C_MWB, 1);
        // sw with one wait cycle
        add(6'b101011, 1, 0, C_FG, 2);  add(6'b101011, 1, 1, C_DEC, 2);
        add(6'b101011, 1, 2, C_MA, 2);  add(6'b101011, 0, 5, C_MWR, 2);
        add(6'b101011, 1, 5, C_MWR, 2);
        // beq, j, jal, addi
        add(6'b000100, 1, 0, C_FG, 3);  add(6'b000100, 1, 1, C_DEC, 3);
        add(6'b000100, 1, 8, C_BR, 3);
        add(6'b000010, 1, 0, C_FG, 4);  add(6'b000010, 1, 1, C_DEC, 4);
        add(6'b000010, 1, 9, C_J, 4);
        add(6'b000011, 1, 0, C_FG, 5);  add(6'b000011, 1, 1, C_DEC, 5);
        add(6'b000011, 1, 12, C_JAL, 5);
        add(6'b001000, 1, 0, C_FG, 6);  add(6'b001000, 1, 1, C_DEC, 6);
        add(6'b001000, 1, 10, C_AEX, 6); add(6'b001000, 1, 11, C_AWB2, 6);
        // illegal opcode
        add(6'b111111, 1, 0, C_FG, 7);  add(6'b111111, 1, 1, C_DILL, 7);
        // fetch timeout with TIMEOUT=4: error on the 5th stalled cycle, then retry
        add(6'b000000, 0, 0, C_FW, 7);  add(6'b000000, 0, 0, C_FW, 7);
        add(6'b000000, 0, 0, C_FW, 7);  add(6'b000000, 0, 0, C_FW, 7);
        add(6'b000000, 0, 0, C_FT, 7);  add(6'b000000, 0, 0, C_FW, 7);
        add(6'b000000, 1, 0, C_FG, 7);  add(6'b000000, 1, 1, C_DEC, 7);
        add(6'b000000, 1, 6, C_EX, 7);  add(6'b000000, 1, 7, C_AWB, 7);
        // ready arriving exactly at the timeout cycle completes normally
        add(6'b100011, 0, 0, C_FW, 8);  add(6'b100011, 0, 0, C_FW, 8);
        add(6'b100011, 0, 0, C_FW, 8);  add(6'b100011, 0, 0, C_FW, 8);
        add(6'b100011, 1, 0, C_FG, 8);  add(6'b100011, 1, 1, C_DEC, 8);
        add(6'b100011, 1, 2, C_MA, 8);
        // MEMRD hang aborts back to FETCH, count unchanged
        add(6'b100011, 0, 3, C_MRD, 8); add(6'b100011, 0, 3, C_MRD, 8);
        add(6'b100011, 0, 3, C_MRD, 8); add(6'b100011, 0, 3, C_MRD, 8);
        add(6'b100011, 0, 3, C_MRDT, 8); add(6'b100011, 0, 0, C_FW, 8);

        bus.opcode    = 6'd0;
        bus.mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_state", 32'(bus.state), 32'd0);
        chk("reset_ctl", 32'(ctl_act), 32'(C_FW));
        chk("reset_retired", bus.instr_retired, 32'd0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            bus.opcode    = vecs[i].op;
            bus.mem_ready = vecs[i].mr;
            #1;
            chk($sformatf("v%0d_state", i), 32'(bus.state), 32'(vecs[i].st));
            chk($sformatf("v%0d_ctl", i), 32'(ctl_act), 32'(vecs[i].ctl));
            chk($sformatf("v%0d_retired", i), bus.instr_retired, 32'(vecs[i].ret));
            $display("vec %0d op=%b mr=%b state=%0d ctl=%h retired=%0d",
                     i, vecs[i].op, vecs[i].mr, bus.state, ctl_act, bus.instr_retired);
        end

        // Reset asserted in the middle of a stalled lw read
        @(negedge clk); bus.opcode = 6'b100011; bus.mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); bus.mem_ready = 1'b0;
        #1;
        chk("midrd_state", 32'(bus.state), 32'd3);
        chk("midrd_iord", 32'(bus.iord), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_midrd_state", 32'(bus.state), 32'd0);
        chk("rst_midrd_ctl", 32'(ctl_act), 32'(C_FW));
        chk("rst_midrd_retired", bus.instr_retired, 32'd0);
        $display("async reset mid-MEMRD state=%0d retired=%0d", bus.state, bus.instr_retired);

        // Reset asserted while a store strobe is active
        @(negedge clk); rst_n = 1'b1; bus.opcode = 6'b101011; bus.mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); bus.mem_ready = 1'b0;
        #1;
        chk("midwr_mem_write", 32'(bus.mem_write), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_midwr_mem_write", 32'(bus.mem_write), 32'd0);
        chk("rst_midwr_state", 32'(bus.state), 32'd0);
        $display("async reset mid-MEMWR state=%0d mem_write=%b", bus.state, bus.mem_write);

        // Counting resumes from zero after reset
        @(negedge clk); rst_n = 1'b1; bus.opcode = 6'b000010; bus.mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("post_rst_retired", bus.instr_retired, 32'd1);
        chk("post_rst_state", 32'(bus.state), 32'd0);
        $display("jump after reset retired=%0d", bus.instr_retired);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
